// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants, state type and AC helpers for the LCD
//               bus responder.
// Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE  = 7'h00;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_BUSY = 2'd2
  } lcd_state_t;

  // Returns {on_screen, cell_index}; both lines share the low nibble as column.
  function automatic logic [5:0] ac_map(input logic [6:0] ac);
    return {(ac[5:4] == 2'b00), ac[6], ac[3:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE1_BASE + 7'h0F) return LINE2_BASE;
      if (ac == LINE2_BASE + 7'h0F) return LINE1_BASE;
      return ac + 7'd1;
    end
    if (ac == LINE2_BASE) return LINE1_BASE + 7'h0F;
    if (ac == LINE1_BASE) return LINE2_BASE + 7'h0F;
    return ac - 7'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_receiver_if
// Description : HD44780-style 8-bit LCD bus between host and responder.
// Revision    : 1.0  initial release
// ============================================================================
interface lcd_bus_receiver_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_rs, lcd_rw, lcd_e, lcd_data_in,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  lcd_rs, lcd_rw, lcd_e, lcd_data_in,
    output lcd_data_out, lcd_data_oe
  );
endinterface
`default_nettype wire

// File: rtl/lcd_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : lcd_strobe_sync
// Description : Synchronizes the asynchronous lcd_e strobe and flags its
//               falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  lcd_e,
  output logic e_sync,
  output logic e_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift form keeps a single-stage chain legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(lcd_e);
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign e_sync = r_sync[SYNC_STAGES-1];
  assign e_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_receiver
// Description : LCD bus responder with 2x16 character mirror, busy flag and
//               address counter emulation.
// Revision    : 1.0  initial release
// ============================================================================
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_SHORT  = 1850,
  parameter int BUSY_LONG   = 76000,
  parameter int SYNC_STAGES = 2
) (
  input  wire               clk,
  input  wire               rst_n,
  lcd_bus_receiver_if.slave bus,
  input  wire  [4:0]        rd_index,
  output logic [7:0]        rd_char,
  output logic              busy,
  output logic [6:0]        addr_ctr,
  output logic              disp_on,
  output logic              cmd_valid,
  output logic [8:0]        last_cmd,
  output logic              err_busy
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  lcd_state_t     r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [4:0]     r_fill_idx, w_fill_nxt;
  logic [6:0]     r_ac, w_ac_nxt;
  logic           r_id, w_id_nxt;
  logic           r_disp, w_disp_nxt;
  logic           r_smp_rs, r_smp_rw;
  logic [7:0]     r_smp_data;
  logic [7:0]     r_mem [32];
  logic           r_cmd_valid, r_err_busy;
  logic [8:0]     r_last_cmd;
  logic           w_e_sync, w_e_fall, w_accept, w_drop, w_busy;
  logic           w_we, w_op_short, w_op_long, w_op_fill;
  logic [5:0]     w_map;
  logic [7:0]     w_ac_char;

  lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .lcd_e  (bus.lcd_e),
    .e_sync (w_e_sync),
    .e_fall (w_e_fall)
  );

  assign w_busy    = (r_state != ST_IDLE);
  assign w_drop    = w_e_fall & ~r_smp_rw & w_busy;
  assign w_accept  = w_e_fall & ~w_drop;
  assign w_map     = ac_map(r_ac);
  assign w_ac_char = w_map[5] ? r_mem[w_map[4:0]] : ASCII_SPACE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fill_nxt  = r_fill_idx;
    w_ac_nxt    = r_ac;
    w_id_nxt    = r_id;
    w_disp_nxt  = r_disp;
    w_we        = 1'b0;
    w_op_short  = 1'b0;
    w_op_long   = 1'b0;
    w_op_fill   = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_fill_nxt = r_fill_idx + 5'd1;
        if (r_fill_idx == 5'd31) begin
          w_state_nxt = ST_BUSY;
          // Fill cycles already consumed 32 of the long busy window.
          w_cnt_nxt   = CW'(BUSY_LONG - 33);
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: ;
    endcase
    if (w_accept) begin
      case ({r_smp_rs, r_smp_rw})
        2'b00: begin
          w_op_short = 1'b1;
          if (|(r_smp_data & CMD_DDRAM))      w_ac_nxt = r_smp_data[6:0];
          else if (|(r_smp_data & (CMD_CGRAM | CMD_FUNC))) w_op_short = 1'b1;
          else if (|(r_smp_data & CMD_SHIFT)) begin
            if (!r_smp_data[3]) w_ac_nxt = ac_step(r_ac, r_smp_data[2]);
          end
          else if (|(r_smp_data & CMD_DISP))  w_disp_nxt = r_smp_data[2];
          else if (|(r_smp_data & CMD_ENTRY)) w_id_nxt = r_smp_data[1];
          else if (|(r_smp_data & CMD_HOME)) begin
            w_ac_nxt  = LINE1_BASE;
            w_op_long = 1'b1;
          end
          else if (|(r_smp_data & CMD_CLEAR)) begin
            w_ac_nxt  = LINE1_BASE;
            w_id_nxt  = 1'b1;
            w_op_fill = 1'b1;
          end
        end
        2'b10: begin
          w_we       = w_map[5];
          w_ac_nxt   = ac_step(r_ac, r_id);
          w_op_short = 1'b1;
        end
        2'b11: begin
          w_ac_nxt   = ac_step(r_ac, r_id);
          w_op_short = 1'b1;
        end
        default: ; // status reads leave the busy window untouched
      endcase
      if (r_state == ST_IDLE) begin
        if (w_op_fill) begin
          w_state_nxt = ST_FILL;
          w_fill_nxt  = 5'd0;
        end else if (w_op_long) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CW'(BUSY_LONG - 1);
        end else if (w_op_short) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CW'(BUSY_SHORT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_fill_idx  <= '0;
      r_ac        <= LINE1_BASE;
      r_id        <= 1'b1;
      r_disp      <= 1'b0;
      r_smp_rs    <= 1'b0;
      r_smp_rw    <= 1'b0;
      r_smp_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_last_cmd  <= '0;
      r_err_busy  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_fill_idx  <= w_fill_nxt;
      r_ac        <= w_ac_nxt;
      r_id        <= w_id_nxt;
      r_disp      <= w_disp_nxt;
      r_cmd_valid <= w_accept;
      if (w_e_sync) begin
        r_smp_rs   <= bus.lcd_rs;
        r_smp_rw   <= bus.lcd_rw;
        r_smp_data <= bus.lcd_data_in;
      end
      if (w_accept) r_last_cmd <= {r_smp_rs, r_smp_data};
      if (w_drop)   r_err_busy <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= ASCII_SPACE;
    end else if (r_state == ST_FILL) begin
      r_mem[r_fill_idx] <= ASCII_SPACE;
    end else if (w_we) begin
      r_mem[w_map[4:0]] <= r_smp_data;
    end
  end

  assign bus.lcd_data_oe  = w_e_sync & bus.lcd_rw;
  assign bus.lcd_data_out = !bus.lcd_data_oe ? 8'h00 :
                            (bus.lcd_rs ? w_ac_char : {w_busy, r_ac});

  assign rd_char   = r_mem[rd_index];
  assign busy      = w_busy;
  assign addr_ctr  = r_ac;
  assign disp_on   = r_disp;
  assign cmd_valid = r_cmd_valid;
  assign last_cmd  = r_last_cmd;
  assign err_busy  = r_err_busy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_bus_receiver
// Description : Self-checking bench for lcd_bus_receiver against a
//               cycle-stamped behavioural model of the LCD controller.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_bus_receiver;

  localparam int SS = 2;
  localparam int BS = 40;
  localparam int BL = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_index = 5'd0;
  logic [7:0] rd_char;
  logic       busy;
  logic [6:0] addr_ctr;
  logic       disp_on;
  logic       cmd_valid;
  logic [8:0] last_cmd;
  logic       err_busy;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  lcd_bus_receiver_if bus();

  lcd_bus_receiver #(.BUSY_SHORT(BS), .BUSY_LONG(BL), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rd_index  (rd_index),
    .rd_char   (rd_char),
    .busy      (busy),
    .addr_ctr  (addr_ctr),
    .disp_on   (disp_on),
    .cmd_valid (cmd_valid),
    .last_cmd  (last_cmd),
    .err_busy  (err_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: busy is high for cycles [start, m_busy_end) as seen after each edge.
  logic [7:0] m_cell [32];
  int         m_ac, m_id, m_disp, m_err, m_busy_end;
  logic [8:0] m_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ac_pos(input int a);
    if (a < 16) return a;
    if (a >= 64 && a < 80) return a - 48;
    return -1;
  endfunction

  function automatic int step_ac(input int a, input int up);
    int p;
    p = ac_pos(a);
    if (p < 0) return up != 0 ? (a + 1) % 128 : (a + 127) % 128;
    p = (up != 0) ? (p + 1) % 32 : (p + 31) % 32;
    return (p / 16) * 64 + p % 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
    m_ac = 0; m_id = 1; m_disp = 0; m_err = 0; m_busy_end = 0; m_last = '0;
  endtask

  task automatic check_cells(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_index = 5'(i);
      #1;
      check_eq($sformatf("%s_cell%0d", tag, i), {24'h0, rd_char}, {24'h0, m_cell[i]});
    end
  endtask

  task automatic wait_idle();
    int start, lim;
    start = cyc;
    lim = cyc + BL + 20;
    while (busy && cyc < lim) begin
      @(posedge clk); #1;
    end
    check_eq("busy_end", cyc, (m_busy_end > start) ? m_busy_end : start);
  endtask

  task automatic access(input bit rs, input bit rw, input logic [7:0] d);
    int c, p, dur, was_busy;
    logic [7:0] exp_rd;
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data_in = d; bus.lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    if (rw) begin
      p = ac_pos(m_ac);
      if (rs) exp_rd = (p < 0) ? 8'h20 : m_cell[p];
      else    exp_rd = {(cyc < m_busy_end) ? 1'b1 : 1'b0, 7'(m_ac)};
      check_eq("rd_oe", {31'h0, bus.lcd_data_oe}, 32'h1);
      check_eq(rs ? "rd_data" : "rd_status", {24'h0, bus.lcd_data_out}, {24'h0, exp_rd});
    end
    bus.lcd_e = 1'b0;
    repeat (SS + 1) @(posedge clk);
    #1;
    c = cyc;
    was_busy = (c - 1 < m_busy_end) ? 1 : 0;
    if (!rw && was_busy != 0) begin
      m_err = 1;
      check_eq("drop_valid", {31'h0, cmd_valid}, 32'h0);
    end else begin
      check_eq("cmd_valid", {31'h0, cmd_valid}, 32'h1);
      m_last = {rs, d};
      dur = BS;
      if (!rs && !rw) begin
        if (d >= 128)      m_ac = int'(d) - 128;
        else if (d >= 32)  dur = BS;
        else if (d >= 16)  begin if (d < 24) m_ac = step_ac(m_ac, (int'(d) / 4) % 2); end
        else if (d >= 8)   m_disp = (int'(d) / 4) % 2;
        else if (d >= 4)   m_id = (int'(d) / 2) % 2;
        else if (d >= 2)   begin m_ac = 0; dur = BL; end
        else if (d == 1)   begin
          for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
          m_ac = 0; m_id = 1; dur = BL;
        end
      end else if (rs) begin
        p = ac_pos(m_ac);
        if (!rw && p >= 0) m_cell[p] = d;
        m_ac = step_ac(m_ac, m_id);
      end else begin
        dur = 0;
      end
      if (was_busy == 0 && dur > 0) m_busy_end = c + dur;
    end
    check_eq("last_cmd", {23'h0, last_cmd}, {23'h0, m_last});
    check_eq("addr_ctr", {25'h0, addr_ctr}, 32'(m_ac));
    check_eq("disp_on", {31'h0, disp_on}, 32'(m_disp));
    check_eq("err_busy", {31'h0, err_busy}, 32'(m_err));
    check_eq("busy_now", {31'h0, busy}, (c < m_busy_end) ? 32'h1 : 32'h0);
    check_eq("oe_off", {31'h0, bus.lcd_data_oe}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ac"}, {25'h0, addr_ctr}, 32'h0);
    check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check_eq({tag, "_disp"}, {31'h0, disp_on}, 32'h0);
    check_eq({tag, "_valid"}, {31'h0, cmd_valid}, 32'h0);
    check_eq({tag, "_last"}, {23'h0, last_cmd}, 32'h0);
    check_eq({tag, "_err"}, {31'h0, err_busy}, 32'h0);
    check_eq({tag, "_oe"}, {31'h0, bus.lcd_data_oe}, 32'h0);
    check_eq({tag, "_dout"}, {24'h0, bus.lcd_data_out}, 32'h0);
  endtask

  initial begin
    bit rs, rw;
    logic [7:0] d;
    int b;
    bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_e = 1'b0; bus.lcd_data_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst");
    check_cells("rst");

    // Set DDRAM 0x45, then a data write on line 2
    access(1'b0, 1'b0, 8'hC5);
    wait_idle();
    access(1'b1, 1'b0, 8'h41);
    check_eq("t2_ac", {25'h0, addr_ctr}, 32'h46);
    wait_idle();
    check_cells("t2");

    // Line wrap on increment and decrement
    access(1'b0, 1'b0, 8'h8F); wait_idle();
    access(1'b1, 1'b0, 8'h41); wait_idle();
    access(1'b1, 1'b0, 8'h42); wait_idle();
    check_eq("t3_ac", {25'h0, addr_ctr}, 32'h41);
    access(1'b0, 1'b0, 8'h04); wait_idle();
    access(1'b0, 1'b0, 8'h80); wait_idle();
    access(1'b1, 1'b0, 8'h43); wait_idle();
    check_eq("t3_dec_ac", {25'h0, addr_ctr}, 32'h4F);
    access(1'b0, 1'b0, 8'h06); wait_idle();
    check_cells("t3");

    // Clear with an overlapping write that must be dropped
    access(1'b0, 1'b0, 8'h01);
    access(1'b1, 1'b0, 8'h7A);
    check_eq("t4_err", {31'h0, err_busy}, 32'h1);
    wait_idle();
    check_cells("t4");

    // Status read while busy, then after the window
    access(1'b1, 1'b0, 8'h5A);
    access(1'b0, 1'b1, 8'h00);
    wait_idle();
    access(1'b0, 1'b1, 8'h00);

    // Randomized traffic, including off-screen AC and accesses while busy
    for (int k = 0; k < 200; k++) begin
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 3) == 0);
      if (!rs && !rw) begin
        b = int'($urandom_range(0, 8));
        if (b == 8) d = 8'h00;
        else        d = 8'(1 << b) | (8'($urandom) & 8'((1 << b) - 1));
      end else begin
        d = 8'($urandom);
      end
      access(rs, rw, d);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      if (k % 40 == 39) begin
        #1;
        wait_idle();
        check_cells("rnd");
      end
    end
    #1;
    wait_idle();

    // Reset in the middle of a clear fill
    access(1'b0, 1'b0, 8'h80); wait_idle();
    access(1'b1, 1'b0, 8'h33); wait_idle();
    access(1'b0, 1'b0, 8'h01);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("t6");
    @(posedge clk); #1;
    check_reset_outputs("t6_next");
    check_cells("t6");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("t6_busy_after", {31'h0, busy}, 32'h0);
    check_cells("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
